// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, in-order
// response FIFO toward the decoder, and redirect handling with stale-response drop.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [AW-1:0] pq_wr, pq_rd;
  logic [AW-1:0] f_wr, f_rd;
  logic [31:0]   pc_q      [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];

  logic          empty;
  logic          fire;
  logic          push;
  logic          pop;
  logic [CW:0]   used;

  assign empty = (fifo_cnt == '0);
  assign pop   = !empty && inst_ready && !redirect_valid;
  assign push  = imem_resp_valid && !redirect_valid && (drop_cnt == '0);

  // A slot freed by this cycle's decoder pop is reusable at once; without it a
  // DEPTH=2 fetch loop bubbles every other cycle.
  assign used = {1'b0, outstanding} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};

  assign imem_req_valid = rst_n && !redirect_valid && (used < DEPTH[CW:0]);
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign inst_valid = !empty;
  assign inst       = empty ? '0 : fifo_inst[f_rd];
  assign inst_pc    = empty ? '0 : fifo_pc[f_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
      f_wr        <= '0;
      f_rd        <= '0;
      fifo_cnt    <= '0;
    end else begin
      if (redirect_valid)
        pc <= {redirect_pc[31:2], 2'b00};
      else if (fire)
        pc <= pc + 32'd4;

      if (fire && !imem_resp_valid)
        outstanding <= outstanding + CW'(1);
      else if (!fire && imem_resp_valid)
        outstanding <= outstanding - CW'(1);

      // Every in-flight response after a redirect is stale, except one landing
      // in the redirect cycle itself, which is discarded directly.
      if (redirect_valid)
        drop_cnt <= outstanding - CW'(imem_resp_valid);
      else if (imem_resp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);

      // The address queue tracks every response, dropped or not, so it is never flushed.
      if (fire)            pq_wr <= pq_wr + AW'(1);
      if (imem_resp_valid) pq_rd <= pq_rd + AW'(1);

      if (redirect_valid) begin
        f_wr     <= '0;
        f_rd     <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) f_wr <= f_wr + AW'(1);
        if (pop)  f_rd <= f_rd + AW'(1);
        if (push && !pop)
          fifo_cnt <= fifo_cnt + CW'(1);
        else if (!push && pop)
          fifo_cnt <= fifo_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire)
      pc_q[pq_wr] <= pc;
    if (push) begin
      fifo_inst[f_wr] <= imem_resp_data;
      fifo_pc[f_wr]   <= pc_q[pq_rd];
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_cnt == DEPTH[CW-1:0])));

endmodule
